// File: rtl/axis_lane_arbiter.sv
// Packet-granular round-robin merge of four AXI Stream lanes into one stream,
// with a one-entry registered output stage that sustains one beat per cycle.
module axis_lane_arbiter #(
   parameter int TDATA_WIDTH = 64,
   parameter int TUSER_WIDTH = 128
) (
   input  logic                         axis_aclk,
   input  logic                         axis_resetn,
   input  logic [4*TDATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [4*TDATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic [4*TUSER_WIDTH-1:0]     s_axis_tuser,
   input  logic [3:0]                   s_axis_tvalid,
   output logic [3:0]                   s_axis_tready,
   input  logic [3:0]                   s_axis_tlast,
   output logic [TDATA_WIDTH-1:0]       m_axis_tdata,
   output logic [TDATA_WIDTH/8-1:0]     m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0]       m_axis_tuser,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic                         m_axis_tlast,
   output logic [1:0]                   grant_id,
   output logic                         busy
);

   localparam int KEEP_WIDTH = TDATA_WIDTH / 8;

   typedef enum logic {
      IDLE   = 1'b0,
      PACKET = 1'b1
   } state_t;

   state_t                  state, state_nxt;
   logic [1:0]              last_grant, last_grant_nxt, grant_nxt;
   logic [1:0]              cand;
   logic                    found;
   logic [3:0]              ready_vec;
   logic                    accept;
   logic                    out_valid;

   logic [TDATA_WIDTH-1:0]  lane_tdata [4];
   logic [KEEP_WIDTH-1:0]   lane_tkeep [4];
   logic [TUSER_WIDTH-1:0]  lane_tuser [4];

   for (genvar i = 0; i < 4; i++) begin : g_unpack
      assign lane_tdata[i] = s_axis_tdata[TDATA_WIDTH*i +: TDATA_WIDTH];
      assign lane_tkeep[i] = s_axis_tkeep[KEEP_WIDTH*i +: KEEP_WIDTH];
      assign lane_tuser[i] = s_axis_tuser[TUSER_WIDTH*i +: TUSER_WIDTH];
   end

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt      = state;
      grant_nxt      = grant_id;
      last_grant_nxt = last_grant;
      ready_vec      = 4'b0000;
      accept         = 1'b0;
      cand           = 2'd0;
      found          = 1'b0;
      unique case (state)
         IDLE: begin
            // Search starts just after the previous winner; +4 wraps back to it last.
            for (int k = 1; k <= 4; k++) begin
               cand = last_grant + 2'(k);
               if (!found && s_axis_tvalid[cand]) begin
                  found     = 1'b1;
                  grant_nxt = cand;
               end
            end
            if (found) state_nxt = PACKET;
         end
         PACKET: begin
            ready_vec[grant_id] = ~out_valid | m_axis_tready;
            accept = s_axis_tvalid[grant_id] & ready_vec[grant_id];
            if (accept && s_axis_tlast[grant_id]) begin
               state_nxt      = IDLE;
               last_grant_nxt = grant_id;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state        <= IDLE;
         grant_id     <= 2'd0;
         last_grant   <= 2'd3;
         out_valid    <= 1'b0;
         m_axis_tdata <= '0;
         m_axis_tkeep <= '0;
         m_axis_tuser <= '0;
         m_axis_tlast <= 1'b0;
      end else begin
         state      <= state_nxt;
         grant_id   <= grant_nxt;
         last_grant <= last_grant_nxt;
         if (accept) begin
            out_valid    <= 1'b1;
            m_axis_tdata <= lane_tdata[grant_id];
            m_axis_tkeep <= lane_tkeep[grant_id];
            m_axis_tuser <= lane_tuser[grant_id];
            m_axis_tlast <= s_axis_tlast[grant_id];
         end else if (m_axis_tready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign s_axis_tready = ready_vec;
   assign m_axis_tvalid = out_valid;
   assign busy          = (state == PACKET);

endmodule

// File: doc/axis_lane_arbiter.md
Name: axis_lane_arbiter

Overview:
Packet-granular round-robin arbiter that merges four narrow AXI Stream lanes into one output stream. Typical sources are the four per-lane output queues of the transmission splitter, or any four equal-width producers. Once a lane is granted, its whole packet (through tlast) is forwarded before another lane is considered. The output is registered through a one-entry pipeline stage with full-throughput backpressure.

Parameters:
TDATA_WIDTH, 64, width of each input lane and of the output tdata
TUSER_WIDTH, 128, width of tuser per lane and on output

Ports:
axis_aclk  input  1  clock
axis_resetn  input  1  reset; asynchronous assert, active-low
s_axis_tdata  input  4*TDATA_WIDTH  lane i data at [TDATA_WIDTH*(i+1)-1 : TDATA_WIDTH*i]
s_axis_tkeep  input  4*TDATA_WIDTH/8  lane i keep, packed the same way
s_axis_tuser  input  4*TUSER_WIDTH  lane i user, packed the same way
s_axis_tvalid  input  4  per-lane valid
s_axis_tready  output  4  per-lane ready
s_axis_tlast  input  4  per-lane last
m_axis_tdata  output  TDATA_WIDTH  merged data
m_axis_tkeep  output  TDATA_WIDTH/8  merged keep
m_axis_tuser  output  TUSER_WIDTH  merged user
m_axis_tvalid  output  1  merged valid
m_axis_tready  input  1  merged ready
m_axis_tlast  output  1  merged last
grant_id  output  2  lane currently or most recently granted
busy  output  1  high while in PACKET state

Behaviour:
- Reset: axis_resetn low asynchronously forces the following:
  - all m_axis_* outputs to 0; s_axis_tready to 4'b0000
  - FSM to IDLE; busy 0; grant_id 0
  - round-robin pointer last_grant to 3, so lane 0 has first priority
- FSM states: IDLE and PACKET.
- IDLE:
  - All s_axis_tready are 0.
  - If any s_axis_tvalid is high, select the first valid lane searching last_grant+1, +2, +3, +4 (mod 4).
  - Register the selected lane in grant_id and go to PACKET on the next edge.
  - Arbitration costs 1 cycle; there is no combinational path from tvalid to tready.
- PACKET:
  - Only the granted lane g may see tready high: s_axis_tready[g] = ~out_valid | m_axis_tready. All other bits are 0.
  - An accepted beat (s_axis_tvalid[g] & s_axis_tready[g]) loads the output register with lane g's tdata, tkeep, tuser and tlast, and sets out_valid.
  - An accepted beat with tlast=1 returns the FSM to IDLE and sets last_grant = g.
  - tvalid[g] dropping mid-packet keeps the grant, with no timeout.
- Output stage:
  - m_axis_tvalid = out_valid. out_valid clears on an output handshake when no new beat loads in the same cycle.
  - Simultaneous output handshake and input accept replaces the register contents, sustaining 1 beat/cycle.
  - While m_axis_tvalid=1 and m_axis_tready=0, all m_axis_* outputs hold stable.
- Latency: input accept to m_axis_tvalid is 1 cycle. A packet boundary costs one idle input cycle (IDLE state), but the output register may still be draining during that cycle.
- Input packing: lanes are packed MSB-first by index; lane 3 occupies the top slice.
- tuser and tkeep pass unmodified per beat. No packet reordering or interleaving occurs on the output.
- Single-beat packets (tlast on the first beat) are legal: IDLE → PACKET → IDLE.
- Reset during PACKET drops the in-flight packet and any buffered beat immediately; the output presents no partial tail afterwards.

Test Plan:
- Lane 2 alone sends a 3-beat packet (data 0xA1, 0xA2, 0xA3; tlast on beat 3) with m_axis_tready=1 → grant_id=2; output shows 0xA1..0xA3 on 3 consecutive cycles, starting 2 cycles after tvalid rises; tlast only on 0xA3; busy falls after the tlast accept.
- All four lanes hold 2-beat packets after reset → output packet order is lanes 0,1,2,3; a second round continues 0,1,2,3; beats never interleave.
- Lane 1 is granted and m_axis_tready toggles 1,0,0,1 mid-packet → output data/keep/user/last stay stable while stalled; s_axis_tready[1] is 0 only while the register is full and stalled; no beat is lost or duplicated.
- Lane 0 sends a packet with a 3-cycle tvalid gap after beat 1, while lane 3 is valid throughout → lane 3's tready stays 0 until lane 0's tlast is accepted; lane 3 is granted next.
- axis_resetn is pulsed low asynchronously (not clock-aligned) mid-packet on lane 2 → m_axis_tvalid=0, s_axis_tready=0 and busy=0 immediately; after release, lane 0 wins when lanes 0 and 2 request together.
- Single-beat packets (tlast=1) on lanes 1 and 3 simultaneously → two 1-beat output packets in order 1 then 3, each with tlast=1.
